contador_gray_param: RTL and testbench

Parametrised synchronous Gray-code counter: next generation of the 5-bit design-under-test counter, generalised in width, with up/down counting, parallel load and selectable wrap/saturate mode. It also has a built-in single-bit-change self-check and a wrap counter. It sits in the same test environment as the existing Gray counters and is driven by the team's probador/checker flow. Behavioural and structural versions must match cycle for cycle.

---
 rtl/contador_gray_param.sv | 103 ++++++++++
 tb/tb_contador_gray_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_gray_param.sv
// Parametrised Gray-code counter with up/down count, parallel load and wrap/saturate
// modes. It also keeps a saturating wrap counter and a sticky single-bit-change self-check.
module contador_gray_param #(
    parameter int WIDTH = 5,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             mode_sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] salida_gray,
    output logic [WIDTH-1:0] salida_bin,
    output logic             at_max,
    output logic             at_min,
    output logic [WRAPW-1:0] vueltas,
    output logic             error_gray
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAPW-1:0] VMAX = '1;
    localparam logic [WRAPW-1:0] VONE = {{(WRAPW-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic one_hot(input logic [WIDTH-1:0] x);
        return (x != ZERO) && ((x & (x - ONE)) == ZERO);
    endfunction

    function automatic logic [WRAPW-1:0] sat_inc(input logic [WRAPW-1:0] v);
        return (v == VMAX) ? v : v + VONE;
    endfunction

    logic [WIDTH-1:0] bin, gray;
    logic [WIDTH-1:0] bin_next, gray_next;
    logic [WRAPW-1:0] wraps;
    logic             err;
    logic             step, wrap;

    always_comb begin
        bin_next = bin;
        step     = 1'b0;
        wrap     = 1'b0;
        if (load) begin
            bin_next = load_value;
        end else if (enable) begin
            if (up_down) begin
                if (bin != MAX) begin
                    bin_next = bin + ONE;
                    step     = 1'b1;
                end else if (!mode_sat) begin
                    bin_next = ZERO;
                    step     = 1'b1;
                    wrap     = 1'b1;
                end
            end else begin
                if (bin != ZERO) begin
                    bin_next = bin - ONE;
                    step     = 1'b1;
                end else if (!mode_sat) begin
                    bin_next = MAX;
                    step     = 1'b1;
                    wrap     = 1'b1;
                end
            end
        end
        gray_next = to_gray(bin_next);
    end

    // State register: one cycle from input sampling to outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin   <= '0;
            gray  <= '0;
            wraps <= '0;
            err   <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            if (wrap) begin
                wraps <= sat_inc(wraps);
            end
            if (step && !one_hot(gray_next ^ gray)) begin
                err <= 1'b1;
            end
        end
    end

    assign salida_bin  = bin;
    assign salida_gray = gray;
    assign vueltas     = wraps;
    assign error_gray  = err;
    assign at_max      = (bin == MAX);
    assign at_min      = (bin == ZERO);

endmodule

// File: tb/tb_contador_gray_param.sv
// Bench for contador_gray_param: a 5-bit and an 8-bit instance share controls; expected
// values come from a vector table and from a small reference model, queued and popped per edge.
module tb_contador_gray_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0, up_down = 1'b0, mode_sat = 1'b0, load = 1'b0;
    logic [4:0] lv5 = '0;
    logic [7:0] lv8 = '0;
    logic [4:0] g5, b5;
    logic [7:0] g8, b8, v5, v8;
    logic       amax5, amin5, err5, amax8, amin8, err8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    contador_gray_param #(.WIDTH(5), .WRAPW(8)) dut5 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .mode_sat(mode_sat), .load(load), .load_value(lv5),
        .salida_gray(g5), .salida_bin(b5), .at_max(amax5), .at_min(amin5),
        .vueltas(v5), .error_gray(err5));

    contador_gray_param #(.WIDTH(8), .WRAPW(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .mode_sat(mode_sat), .load(load), .load_value(lv8),
        .salida_gray(g8), .salida_bin(b8), .at_max(amax8), .at_min(amin8),
        .vueltas(v8), .error_gray(err8));

    typedef struct {
        string      name;
        logic [4:0] bin5;
        logic [4:0] gray5;
        logic [7:0] vue5;
        bit         has8;
        logic [7:0] bin8;
        logic [7:0] vue8;
    } exp_t;

    typedef struct {
        bit         rst, en, up, sat, ld;
        logic [4:0] lv;
        logic [4:0] bin;
        logic [4:0] gray;
        logic [7:0] vue;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[20];

    logic [4:0] m5;
    logic [7:0] m8, mv5, mv8;

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [7:0] vinc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check_top();
        exp_t e;
        logic [7:0] dec5, dec8, eg8;
        logic ok;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        dec5 = g2b({3'b000, g5});
        vectors++;
        ok = (g5 === e.gray5) && (b5 === e.bin5) && (v5 === e.vue5) && (err5 === 1'b0)
             && (amax5 === (e.bin5 == 5'd31)) && (amin5 === (e.bin5 == 5'd0))
             && (dec5[4:0] === b5);
        if (!ok) begin
            miscompares++;
            $display("FAIL %s w5: got gray=%b bin=%0d vue=%0d err=%b max=%b min=%b, want gray=%b bin=%0d vue=%0d err=0",
                     e.name, g5, b5, v5, err5, amax5, amin5, e.gray5, e.bin5, e.vue5);
        end
        if (e.has8) begin
            dec8 = g2b(g8);
            eg8  = e.bin8 ^ (e.bin8 >> 1);
            vectors++;
            ok = (g8 === eg8) && (b8 === e.bin8) && (v8 === e.vue8) && (err8 === 1'b0)
                 && (amax8 === (e.bin8 == 8'd255)) && (amin8 === (e.bin8 == 8'd0))
                 && (dec8 === b8);
            if (!ok) begin
                miscompares++;
                $display("FAIL %s w8: got gray=%b bin=%0d vue=%0d err=%b, want gray=%b bin=%0d vue=%0d err=0",
                         e.name, g8, b8, v8, err8, eg8, e.bin8, e.vue8);
            end
        end
    endtask

    task automatic apply(input bit rst, en, up, sat, ld, input logic [7:0] lv, input exp_t e);
        @(negedge clk);
        reset    = rst;
        enable   = en;
        up_down  = up;
        mode_sat = sat;
        load     = ld;
        lv5      = lv[4:0];
        lv8      = lv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_top();
    endtask

    task automatic mstep(input string name, input bit rst, en, up, sat, ld, input logic [7:0] lv);
        exp_t e;
        if (rst) begin
            m5 = '0; m8 = '0; mv5 = '0; mv8 = '0;
        end else if (ld) begin
            m5 = lv[4:0];
            m8 = lv;
        end else if (en) begin
            if (up) begin
                if (m5 != 5'd31) m5 = m5 + 5'd1;
                else if (!sat) begin m5 = 5'd0; mv5 = vinc(mv5); end
                if (m8 != 8'd255) m8 = m8 + 8'd1;
                else if (!sat) begin m8 = 8'd0; mv8 = vinc(mv8); end
            end else begin
                if (m5 != 5'd0) m5 = m5 - 5'd1;
                else if (!sat) begin m5 = 5'd31; mv5 = vinc(mv5); end
                if (m8 != 8'd0) m8 = m8 - 8'd1;
                else if (!sat) begin m8 = 8'd255; mv8 = vinc(mv8); end
            end
        end
        e.name  = name;
        e.bin5  = m5;
        e.gray5 = m5 ^ (m5 >> 1);
        e.vue5  = mv5;
        e.has8  = 1'b1;
        e.bin8  = m8;
        e.vue8  = mv8;
        apply(rst, en, up, sat, ld, lv, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // rst en up sat ld lv  -> bin gray vue
        tbl[0]  = '{1,0,0,0,0, 5'd0,  5'd0,  5'b00000, 8'd0};
        tbl[1]  = '{0,1,0,0,0, 5'd0,  5'd31, 5'b10000, 8'd1};
        tbl[2]  = '{1,0,0,0,0, 5'd0,  5'd0,  5'b00000, 8'd0};
        tbl[3]  = '{0,0,1,1,1, 5'd30, 5'd30, 5'b10001, 8'd0};
        tbl[4]  = '{0,1,1,1,0, 5'd0,  5'd31, 5'b10000, 8'd0};
        tbl[5]  = '{0,1,1,1,0, 5'd0,  5'd31, 5'b10000, 8'd0};
        tbl[6]  = '{0,1,1,1,0, 5'd0,  5'd31, 5'b10000, 8'd0};
        tbl[7]  = '{0,1,1,0,1, 5'd12, 5'd12, 5'b01010, 8'd0};
        tbl[8]  = '{0,1,1,0,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[9]  = '{0,0,1,0,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[10] = '{0,0,1,0,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[11] = '{0,0,0,0,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[12] = '{0,0,0,1,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[13] = '{0,1,0,0,0, 5'd0,  5'd12, 5'b01010, 8'd0};
        tbl[14] = '{0,1,1,0,0, 5'd0,  5'd13, 5'b01011, 8'd0};
        tbl[15] = '{0,0,0,0,1, 5'd0,  5'd0,  5'b00000, 8'd0};
        tbl[16] = '{0,1,0,1,0, 5'd0,  5'd0,  5'b00000, 8'd0};
        tbl[17] = '{0,1,1,1,0, 5'd0,  5'd1,  5'b00001, 8'd0};
        tbl[18] = '{0,1,1,0,1, 5'd31, 5'd31, 5'b10000, 8'd0};
        tbl[19] = '{0,1,1,0,0, 5'd0,  5'd0,  5'b00000, 8'd1};

        // Reset state, then a full 5-bit up sweep in wrap mode.
        mstep("reset", 1, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 32; i++) mstep("up_wrap5", 0, 1, 1, 0, 0, 8'd0);

        // Literal vectors for the directed corner cases.
        for (int i = 0; i < 20; i++) begin
            e.name  = $sformatf("tbl%0d", i);
            e.bin5  = tbl[i].bin;
            e.gray5 = tbl[i].gray;
            e.vue5  = tbl[i].vue;
            e.has8  = 1'b0;
            e.bin8  = '0;
            e.vue8  = '0;
            apply(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].ld, {3'b000, tbl[i].lv}, e);
        end

        // Reset pulsed between edges at count 17 must clear before the next edge.
        mstep("reset2", 1, 0, 0, 0, 0, 8'd0);
        mstep("ld17", 0, 0, 1, 0, 1, 8'd17);
        @(negedge clk);
        enable = 1'b1;
        reset  = 1'b1;
        m5 = '0; m8 = '0; mv5 = '0; mv8 = '0;
        e = '{"async_reset", 5'd0, 5'd0, 8'd0, 1'b1, 8'd0, 8'd0};
        exp_q.push_back(e);
        #2;
        check_top();
        enable = 1'b0;

        // Random mix of load/enable/direction/mode against the model.
        for (int i = 0; i < 120; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            mstep("random", 0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), r);
        end

        // 8-bit full sweep from reset: exactly one wrap.
        mstep("reset3", 1, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 256; i++) mstep("sweep8", 0, 1, 1, 0, 0, 8'd0);

        // Drive the wrap counter into saturation with load-0 / step-down pairs.
        mstep("reset4", 1, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 260; i++) begin
            mstep("vsat_ld", 0, 1, 0, 0, 1, 8'd0);
            mstep("vsat_dn", 0, 1, 0, 0, 0, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
